// File: rtl/im_loader_if.sv
// Byte-stream handshake between a boot image source and the IM loader.
//   byte_in    : stream data byte (source -> loader)
//   byte_valid : byte_in holds a valid byte (source -> loader)
//   byte_ready : loader takes the byte this cycle (loader -> source)
// A byte moves on any rising edge where byte_valid and byte_ready are both 1.
interface im_loader_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_in, output byte_valid, input byte_ready);
    modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/im_loader.sv
// im_loader: boot-time instruction memory writer.
// Packs a byte stream big-endian into 32-bit words and writes them to
// consecutive IM byte addresses starting at BASE_ADDR, holding the CPU until
// the requested number of words has been written.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   start, len : one-cycle request to load len words (len sampled on start)
//   bs         : byte stream (slave side of im_loader_if)
//   im_we, im_addr, im_wdata : IM write port, one strobe per word
//   cpu_hold   : 1 while loading
//   done       : load finished, held until the next accepted start
//   len_err    : requested len exceeded DEPTH and was clamped
module im_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int          DEPTH     = 1024,
    parameter int          LEN_W     = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    im_loader_if.slave       bs,
    output logic             im_we,
    output logic [31:0]      im_addr,
    output logic [31:0]      im_wdata,
    output logic             cpu_hold,
    output logic             done,
    output logic             len_err
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [31:0]      part_q, part_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             we_q, we_d;
    logic             len_err_q, len_err_d;

    logic [LEN_W-1:0] len_clamped;
    logic [31:0]      word_next;
    logic             start_acc;
    logic             last_wr;
    logic             ready;
    logic             xfer;

    assign len_clamped = (len > DEPTH_L) ? DEPTH_L : len;
    assign start_acc   = start && (state_q != S_LOAD);
    // The write cycle of the final word: no further byte may be taken.
    assign last_wr     = we_q && (word_idx_q == len_q - LEN_W'(1));
    assign xfer        = ready && bs.byte_valid;
    assign word_next   = {part_q[23:0], bs.byte_in};

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_acc) state_d = (len_clamped == '0) ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
                if (last_wr) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready    = 1'b0;
        cpu_hold = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                ready    = !last_wr;
                cpu_hold = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign bs.byte_ready = ready;

    // Datapath next state: byte packing, word index and write port
    always_comb begin
        len_d      = len_q;
        len_err_d  = len_err_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        part_d     = part_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        if (start_acc) begin
            len_d      = len_clamped;
            len_err_d  = (len > DEPTH_L);
            word_idx_d = '0;
            byte_cnt_d = '0;
            part_d     = '0;
        end else begin
            // word_idx_q still names the word being written during the
            // write cycle; it advances afterwards.
            if (we_q) word_idx_d = word_idx_q + LEN_W'(1);
            if (xfer) begin
                part_d     = word_next;
                byte_cnt_d = byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3 && word_idx_q < DEPTH_L) begin
                    we_d    = 1'b1;
                    addr_d  = BASE_ADDR + {{(30-LEN_W){1'b0}}, word_idx_q, 2'b00};
                    wdata_d = word_next;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q      <= '0;
            len_err_q  <= 1'b0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            part_q     <= '0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= '0;
            we_q       <= 1'b0;
        end else begin
            len_q      <= len_d;
            len_err_q  <= len_err_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            part_q     <= part_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
        end
    end

    assign im_we    = we_q;
    assign im_addr  = addr_q;
    assign im_wdata = wdata_q;
    assign len_err  = len_err_q;
endmodule

// File: tb/tb_im_loader.sv
module tb_im_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] len;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        done;
    logic        len_err;

    im_loader_if bs_if ();

    im_loader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .bs       (bs_if),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .len_err  (len_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed transfers and writes; a transfer seen at negedge of cycle c
    // completes on the following rising edge.
    int          xcyc[$];
    logic [7:0]  xbyte[$];
    int          wcyc[$];
    logic [31:0] waddr[$];
    logic [31:0] wdat[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (bs_if.byte_valid && bs_if.byte_ready) begin
                xcyc.push_back(cyc);
                xbyte.push_back(bs_if.byte_in);
            end
            if (im_we) begin
                wcyc.push_back(cyc);
                waddr.push_back(im_addr);
                wdat.push_back(im_wdata);
            end
        end
    end

    logic [7:0] src [0:4199];

    typedef struct {
        int   ln;
        int   vmode;   // 0 always valid, 1 toggling, 2 random
        int   mid;     // pulse start again during the load
        logic err;
        int   nexp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fill_src();
        for (int i = 0; i < 4200; i++) src[i] = 8'($urandom);
    endtask

    task automatic clear_obs();
        xcyc.delete(); xbyte.delete();
        wcyc.delete(); waddr.delete(); wdat.delete();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " byte_ready"}, 32'(bs_if.byte_ready), 0);
        chk({tag, " im_we"},      32'(im_we), 0);
        chk({tag, " im_addr"},    im_addr, 32'h3000);
        chk({tag, " im_wdata"},   im_wdata, 0);
        chk({tag, " cpu_hold"},   32'(cpu_hold), 0);
        chk({tag, " done"},       32'(done), 0);
        chk({tag, " len_err"},    32'(len_err), 0);
    endtask

    // Start a load of ln words, feed bytes from src, and compare against the
    // model: word k = src[4k..4k+3] big-endian at 0x3000+4k, written the
    // cycle after its 4th byte transfers, min(ln,1024) words in total.
    task automatic run_load(input int ln, input int vmode, input int mid,
                            input logic exp_err, input int nexp, input string tag);
        int ptr = 0;
        int budget = 0;
        bit mid_done = 0;
        bit v;
        @(posedge clk); #1;
        clear_obs();
        start = 1'b1;
        len   = 11'(ln);
        @(posedge clk); #1;
        start = 1'b0;
        len   = 11'($urandom);
        @(negedge clk);
        chk({tag, " done_after_start"}, 32'(done), 32'(ln == 0));
        chk({tag, " hold_after_start"}, 32'(cpu_hold), 32'(ln != 0));
        while (!done && budget < 20000) begin
            @(posedge clk); #1;
            case (vmode)
                0:       v = 1'b1;
                1:       v = (budget % 2) == 0;
                default: v = 1'($urandom_range(0, 1));
            endcase
            bs_if.byte_valid = v;
            bs_if.byte_in    = src[ptr];
            if (mid != 0 && !mid_done && ptr >= 5) begin
                start    = 1'b1;
                len      = 11'd1;
                mid_done = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (v && bs_if.byte_ready) ptr++;
            budget++;
        end
        chk({tag, " no_timeout"}, 32'(budget < 20000), 1);
        // Keep offering bytes after completion: none may be taken.
        repeat (3) begin
            @(posedge clk); #1;
            start = 1'b0;
            bs_if.byte_valid = 1'b1;
            bs_if.byte_in    = 8'hEE;
        end
        @(negedge clk);
        bs_if.byte_valid = 1'b0;
        chk({tag, " n_writes"},  32'(wcyc.size()), 32'(nexp));
        chk({tag, " n_bytes"},   32'(xcyc.size()), 32'(4 * nexp));
        chk({tag, " done"},      32'(done), 1);
        chk({tag, " cpu_hold"},  32'(cpu_hold), 0);
        chk({tag, " len_err"},   32'(len_err), 32'(exp_err));
        chk({tag, " ready_off"}, 32'(bs_if.byte_ready), 0);
        for (int k = 0; k < nexp && k < wcyc.size(); k++) begin
            chk($sformatf("%s addr[%0d]", tag, k), waddr[k], 32'h3000 + 32'(4 * k));
            chk($sformatf("%s data[%0d]", tag, k), wdat[k],
                {src[4*k], src[4*k+1], src[4*k+2], src[4*k+3]});
            if (4 * k + 3 < xcyc.size())
                chk($sformatf("%s latency[%0d]", tag, k), 32'(wcyc[k]), 32'(xcyc[4*k+3] + 1));
        end
    endtask

    vec_t tbl[7];

    initial begin
        tbl = '{
            '{1,    0, 0, 1'b0, 1},
            '{3,    0, 0, 1'b0, 3},
            '{2,    1, 0, 1'b0, 2},
            '{0,    0, 0, 1'b0, 0},
            '{2000, 0, 0, 1'b1, 1024},
            '{3,    0, 1, 1'b0, 3},
            '{1025, 2, 0, 1'b1, 1024}
        };

        reset = 1'b1;
        start = 1'b0;
        len   = '0;
        bs_if.byte_valid = 1'b0;
        bs_if.byte_in    = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("reset");

        // Bytes offered while idle are never consumed.
        clear_obs();
        repeat (3) begin
            @(posedge clk); #1;
            bs_if.byte_valid = 1'b1;
            bs_if.byte_in    = 8'h5A;
        end
        @(negedge clk);
        chk("idle_no_xfer", 32'(xcyc.size()), 0);
        @(posedge clk); #1 bs_if.byte_valid = 1'b0;

        for (int i = 0; i < 7; i++) begin
            fill_src();
            if (i == 0) begin
                src[0] = 8'h8C; src[1] = 8'h01; src[2] = 8'h00; src[3] = 8'h04;
            end
            run_load(tbl[i].ln, tbl[i].vmode, tbl[i].mid, tbl[i].err, tbl[i].nexp,
                     $sformatf("vec%0d", i));
            if (i == 0 && wdat.size() > 0) chk("vec0 word_8C010004", wdat[0], 32'h8C010004);
            if (i == 4 && waddr.size() > 0) chk("vec4 last_addr", waddr[waddr.size()-1], 32'h3FFC);
        end

        // Reset partway through word 1 of a 2-word load.
        fill_src();
        clear_obs();
        @(posedge clk); #1;
        start = 1'b1;
        len   = 11'd2;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bs_if.byte_valid = 1'b1;
            bs_if.byte_in    = src[i];
            @(posedge clk); #1;
        end
        bs_if.byte_valid = 1'b0;
        chk("midrst word0_written", 32'(wcyc.size()), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst");
        src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33; src[3] = 8'h44;
        run_load(1, 0, 0, 1'b0, 1, "after_rst");
        if (wdat.size() > 0) chk("after_rst word", wdat[0], 32'h11223344);

        // Randomized loads against the model.
        for (int r = 0; r < 6; r++) begin
            int ln;
            ln = $urandom_range(1, 40);
            fill_src();
            run_load(ln, $urandom_range(0, 2), $urandom_range(0, 1), 1'b0,
                     (ln > 1024) ? 1024 : ln, $sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
